nios2e_cpu_debug_cmd_queue: RTL
===============================

Name: nios2e_cpu_debug_cmd_queue

Overview:
System-clock side of the CPU debug slave, generalised to a parametrised number of instruction channels, data width and synchroniser depth. It synchronises the virtual-JTAG update strobes and captures the TCK-domain shift register and IR into a small command FIFO, so back-to-back JTAG updates are not lost. It presents commands with a valid/ready handshake and issues one-hot take_action / take_no_action pulses per channel. It sits between the TCK-domain debug slave and the OCI break, ocimem and trace-control logic.

Parameters:
DATA_W, 38, width of sr and jdo
IR_W, 2, virtual-JTAG IR width; NUM_CH = 2**IR_W channels
SYNC_STAGES, 2, synchroniser flops on vs_udr/vs_uir (legal 2..4)
FIFO_DEPTH, 4, command queue entries (power of 2, legal 2..16)
ACTION_BIT, 34, jdo bit selecting take_action (1) vs take_no_action (0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  DATA_W  TCK-domain shift register, stable while vs_udr is high
ir_in  in  IR_W  TCK-domain IR, stable while vs_uir is high
vs_udr  in  1  async update-DR level from virtual JTAG
vs_uir  in  1  async update-IR level from virtual JTAG
cmd_ready  in  1  consumer accepts head command
clear_overflow  in  1  clears overflow flag
jdo  out  DATA_W  data of last popped command
cmd_valid  out  1  FIFO non-empty
cmd_ch  out  IR_W  channel of head command
take_action  out  NUM_CH  one-hot, one-cycle pulse
take_no_action  out  NUM_CH  one-hot, one-cycle pulse
overflow  out  1  sticky, command dropped while full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync deassert via flops): all sync flops, ir register, FIFO pointers, jdo, take_action, take_no_action and overflow are 0; cmd_valid=0, fifo_level=0.
- Synchronisers: SYNC_STAGES flops each on vs_udr and vs_uir, plus one history flop per signal. Rising-edge detect is udr_rise = sync & ~hist, and likewise uir_rise.
- On uir_rise: ir_reg <= ir_in.
- On udr_rise: push {ir_reg, sr} into the FIFO.
  - If uir_rise and udr_rise fall in the same cycle, the push uses the old ir_reg.
- Latency: vs_udr goes high before edge 1, so udr_rise is high after edge SYNC_STAGES. The entry is written at edge SYNC_STAGES+1, and cmd_valid goes high after that edge (first-word-fall-through).
- cmd_ch reflects the head entry. Head data is not visible until popped.
- Pop occurs when cmd_valid && cmd_ready. At that edge:
  - jdo <= head data.
  - If head data[ACTION_BIT]=1, take_action[head ch] is set for exactly one cycle; otherwise take_no_action[head ch] is set for one cycle.
  - The pulse coincides with the new jdo value. Both pulse vectors are otherwise 0 and never both non-zero.
- Pop when empty: ignored, no pulse.
- Full push: the command is dropped, FIFO unchanged, overflow <= 1.
  - Simultaneous push and pop while full: push accepted, level unchanged, no overflow.
- Simultaneous push and pop at any level: level unchanged, ordering preserved.
- overflow is sticky until clear_overflow. If a clear and a new overflow happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_level = wr_count - rd_count, using an extra MSB to tell full from empty.
- Reset mid-operation discards queued commands; no pulse is emitted after reset.
- vs_udr held high produces only one push; the next push needs a low-to-high transition.

Decomposition:
- Package nios2e_debug_pkg holds: the ir channel constants (CH_OCIMEM=0, CH_TRACE=1, CH_BREAK=2, CH_BREAK_C=3), the default DATA_W/ACTION_BIT, and a cmd_t struct {ch, data}.
- Sub-module nios2e_debug_sync_edge (SYNC_STAGES param; async-reset synchroniser plus rising-edge detect), instantiated twice.
- The FIFO stays inline.

Test Plan:
- Reset, then pulse vs_uir with ir_in=2, then pulse vs_udr with sr=38'h04_0000_0001 (bit34=1) and cmd_ready=1 -> cmd_valid rises 3 cycles after udr (SYNC_STAGES=2); next cycle take_action=4'b0100, jdo=38'h04_0000_0001.
- sr bit34=0, ir=0 -> take_no_action=4'b0001 for exactly one cycle, take_action stays 0.
- cmd_ready=0, 5 udr pulses with sr=1..5 -> fifo_level=4, overflow=1, entries 1..4 kept; then cmd_ready=1 -> jdo sequence 1,2,3,4 on consecutive cycles.
- Full FIFO with a push and pop in the same cycle -> level stays 4, overflow unchanged; clear_overflow together with a new drop -> overflow stays 1.
- vs_udr held high for 20 cycles -> exactly one push; assert reset_n=0 while 3 entries are queued -> all outputs 0 immediately, no pulses after release.

Source files
------------

// File: rtl/nios2e_debug_pkg.sv
// nios2e_debug_pkg: channel constants, default widths and command record for the debug command queue.
package nios2e_debug_pkg;
    localparam int DEF_DATA_W     = 38;
    localparam int DEF_IR_W       = 2;
    localparam int DEF_ACTION_BIT = 34;

    localparam logic [DEF_IR_W-1:0] CH_OCIMEM  = 2'd0;
    localparam logic [DEF_IR_W-1:0] CH_TRACE   = 2'd1;
    localparam logic [DEF_IR_W-1:0] CH_BREAK   = 2'd2;
    localparam logic [DEF_IR_W-1:0] CH_BREAK_C = 2'd3;

    typedef struct packed {
        logic [DEF_IR_W-1:0]   ch;
        logic [DEF_DATA_W-1:0] data;
    } cmd_t;
endpackage

// File: rtl/nios2e_debug_sync_edge.sv
// nios2e_debug_sync_edge: multi-flop synchroniser for an async level with rising-edge detect.
module nios2e_debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
endmodule

// File: rtl/nios2e_cpu_debug_cmd_queue.sv
// nios2e_cpu_debug_cmd_queue: system-clock side of the CPU debug slave; queues JTAG updates
// and issues one-hot take_action / take_no_action pulses as commands are popped.
module nios2e_cpu_debug_cmd_queue
    import nios2e_debug_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTION_BIT  = DEF_ACTION_BIT,
    localparam int NUM_CH     = 2**IR_W,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic              cmd_ready,
    input  logic              clear_overflow,
    output logic [DATA_W-1:0] jdo,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ch,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              overflow,
    output logic [LW-1:0]     fifo_level
);
    localparam int AW = LW - 1;

    typedef struct packed {
        logic [IR_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              w_udr_rise, w_uir_rise, w_full, w_pop, w_push;
    logic [NUM_CH-1:0] w_onehot;
    entry_t            w_head;
    entry_t            r_mem [FIFO_DEPTH];
    logic [LW-1:0]     r_wr, r_rd;
    logic [IR_W-1:0]   r_ir;

    nios2e_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr (
        .clk(clk), .reset_n(reset_n), .i_async(vs_udr), .o_rise(w_udr_rise)
    );
    nios2e_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir (
        .clk(clk), .reset_n(reset_n), .i_async(vs_uir), .o_rise(w_uir_rise)
    );

    // Extra pointer MSB distinguishes full from empty.
    assign fifo_level = r_wr - r_rd;
    assign cmd_valid  = fifo_level != '0;
    assign w_full     = fifo_level == LW'(FIFO_DEPTH);
    assign w_pop      = cmd_valid & cmd_ready;
    assign w_push     = w_udr_rise & (~w_full | w_pop);
    assign w_head     = r_mem[r_rd[AW-1:0]];
    assign cmd_ch     = w_head.ch;
    assign w_onehot   = NUM_CH'(1) << w_head.ch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr           <= '0;
            r_rd           <= '0;
            r_ir           <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overflow       <= 1'b0;
        end else begin
            r_ir <= w_uir_rise ? ir_in : r_ir;
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= '{ch: r_ir, data: sr};
                r_wr                <= r_wr + LW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + LW'(1);
                jdo  <= w_head.data;
            end
            take_action    <= (w_pop &  w_head.data[ACTION_BIT]) ? w_onehot : '0;
            take_no_action <= (w_pop & ~w_head.data[ACTION_BIT]) ? w_onehot : '0;
            overflow       <= (w_udr_rise & w_full & ~w_pop) | (overflow & ~clear_overflow);
        end
    end
endmodule
